// File: rtl/spi_slave_seq_ctrl.sv
// Sequencer that owns the SPI slave register port: initialises the slave, then moves words between it and RX/TX streams.
// Status polling with the saturating error counter is built only when SPI_SEQ_STATUS_POLL_EN is defined.
module spi_slave_seq_ctrl #(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] EOP_VALUE = 16'hFFFF,
    parameter int unsigned       ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 spi_select,
    output logic [2:0]           mem_addr,
    output logic                 read_n,
    output logic                 write_n,
    output logic [DATA_W-1:0]    data_from_cpu,
    input  logic [DATA_W-1:0]    data_to_cpu,
    input  logic                 dataavailable,
    input  logic                 readyfordata,
    input  logic                 endofpacket,
    output logic [DATA_W-1:0]    rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_eop,
    input  logic [DATA_W-1:0]    tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 init_done
);

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_EOP     = 3'd6;

    typedef enum logic [3:0] {
        S_INIT_EOP,
        S_INIT_CLR,
        S_INIT_CTL,
        S_IDLE,
        S_RD,
        S_WR,
        S_EOP_CLR,
        S_POLL_RD,
        S_POLL_CLR
    } state_t;

    // GAP is the strobes-high cycle that precedes every access not launched from IDLE
    typedef enum logic [1:0] {
        PH_GAP,
        PH_A1,
        PH_A2
    } phase_t;

    state_t              state;
    phase_t              phase;
    logic [2:0]          acc_addr;
    logic                acc_write;
    logic [DATA_W-1:0]   acc_wdata;
    logic                rd_eop;

`ifdef SPI_SEQ_STATUS_POLL_EN
    localparam int unsigned STATUS_E_BIT = 8;
    logic [5:0] idle_cnt;
`else
    assign err_count = '0;
`endif

    assign rd_eop = endofpacket | (data_to_cpu == EOP_VALUE);

    // Access launched from the GAP phase of each chained state
    always_comb begin
        acc_addr  = ADDR_RXDATA;
        acc_write = 1'b0;
        acc_wdata = '0;
        case (state)
            S_INIT_EOP: begin
                acc_addr  = ADDR_EOP;
                acc_write = 1'b1;
                acc_wdata = EOP_VALUE;
            end
            S_INIT_CLR, S_EOP_CLR, S_POLL_CLR: begin
                acc_addr  = ADDR_STATUS;
                acc_write = 1'b1;
            end
            S_INIT_CTL: begin
                acc_addr  = ADDR_CONTROL;
                acc_write = 1'b1;
            end
            S_POLL_RD: acc_addr = ADDR_STATUS;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_INIT_EOP;
            phase         <= PH_GAP;
            spi_select    <= 1'b0;
            mem_addr      <= '0;
            read_n        <= 1'b1;
            write_n       <= 1'b1;
            data_from_cpu <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_eop        <= 1'b0;
            tx_ready      <= 1'b0;
            init_done     <= 1'b0;
`ifdef SPI_SEQ_STATUS_POLL_EN
            err_count     <= '0;
            idle_cnt      <= '0;
`endif
        end else begin
            tx_ready <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                rx_eop   <= 1'b0;
            end

            if (state == S_IDLE) begin
                // A word being accepted this cycle frees the RX slot, so RD may start now
                if (dataavailable && (!rx_valid || rx_ready)) begin
                    state      <= S_RD;
                    phase      <= PH_A1;
                    spi_select <= 1'b1;
                    read_n     <= 1'b0;
                    mem_addr   <= ADDR_RXDATA;
                end else if (readyfordata && tx_valid) begin
                    state         <= S_WR;
                    phase         <= PH_A1;
                    spi_select    <= 1'b1;
                    write_n       <= 1'b0;
                    mem_addr      <= ADDR_TXDATA;
                    data_from_cpu <= tx_data;
                end
`ifdef SPI_SEQ_STATUS_POLL_EN
                else if (idle_cnt == '1) begin
                    idle_cnt <= '0;
                    state    <= S_POLL_RD;
                    phase    <= PH_GAP;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
`endif
            end else begin
                case (phase)
                    PH_A1: begin
                        phase <= PH_A2;
                        if (state == S_WR)
                            tx_ready <= 1'b1;
                    end
                    PH_A2: begin
                        phase      <= PH_GAP;
                        spi_select <= 1'b0;
                        read_n     <= 1'b1;
                        write_n    <= 1'b1;
                        case (state)
                            S_INIT_EOP: state <= S_INIT_CLR;
                            S_INIT_CLR: state <= S_INIT_CTL;
                            S_INIT_CTL: begin
                                state     <= S_IDLE;
                                init_done <= 1'b1;
                            end
                            S_RD: begin
                                rx_data  <= data_to_cpu;
                                rx_eop   <= rd_eop;
                                rx_valid <= 1'b1;
                                state    <= rd_eop ? S_EOP_CLR : S_IDLE;
                            end
`ifdef SPI_SEQ_STATUS_POLL_EN
                            S_POLL_RD: begin
                                if (data_to_cpu[STATUS_E_BIT]) begin
                                    if (err_count != '1)
                                        err_count <= err_count + 1'b1;
                                    state <= S_POLL_CLR;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end
`endif
                            default: state <= S_IDLE;
                        endcase
                    end
                    default: begin
                        phase         <= PH_A1;
                        spi_select    <= 1'b1;
                        mem_addr      <= acc_addr;
                        write_n       <= !acc_write;
                        read_n        <= acc_write;
                        data_from_cpu <= acc_wdata;
                    end
                endcase
            end
        end
    end

endmodule
